ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 clk  in  1  rising-edge clock; only clock in the block.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  decoded control bundle for the instruction in ID.
REQ-004 ALUOp  in  2  decoded ALU operation class for the ID instruction.
REQ-005 id_rs, id_rt, id_rd  in  5 each  register fields of the ID instruction.
REQ-006 ex_zero  in  1  ALU zero flag of the EX instruction.
REQ-007 ex_RegDst, ex_ALUSrc  out  1 each; ex_ALUOp  out  2  EX-stage controls.
REQ-008 mem_MemRead, mem_MemWrite  out  1 each  MEM-stage controls.
REQ-009 wb_RegWrite, wb_MemtoReg  out  1 each  WB-stage controls.
REQ-010 ex_wreg, mem_wreg, wb_wreg  out  5 each  destination register per stage.
REQ-011 forwardA, forwardB  out  2 each  ALU operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-012 PCWrite, IFIDWrite  out  1 each  0 = hold PC / IF-ID register.
REQ-013 PCSrc  out  1  taken branch in MEM; also drives if_flush  out  1  (same value).
REQ-014 stall_cnt  out  16  count of load-use stall cycles since reset.

Function
REQ-015 Three control registers shall exist: ID/EX, EX/MEM, MEM/WB; each advances one stage per clk when not reset.
REQ-016 ID/EX shall capture the ID bundle plus id_rs, id_rt, and ex_wreg = RegDst ? id_rd : id_rt.
REQ-017 EX/MEM shall capture MemRead, MemWrite, Branch, RegWrite, MemtoReg, ex_wreg, and ex_zero.
REQ-018 MEM/WB shall capture RegWrite, MemtoReg, mem_wreg.
REQ-019 Load-use hazard (combinational): ex_MemRead=1, ex_rt!=0, and (ex_rt==id_rs or ex_rt==id_rt).
REQ-020 On a hazard: PCWrite=0, IFIDWrite=0, and ID/EX loads an all-zero bubble (all control bits 0, wreg 0) on the next edge; EX/MEM and MEM/WB still advance.
REQ-021 PCSrc = mem_Branch AND the registered zero flag, combinational from EX/MEM.
REQ-022 PCSrc=1: on the next edge ID/EX and EX/MEM load bubbles; the MEM/WB load is unaffected.
REQ-023 Hazard and PCSrc in the same cycle: the flush wins; PCWrite=1, IFIDWrite=1, stall_cnt does not increment.
REQ-024 forwardA=10 when mem_RegWrite=1, mem_wreg!=0, and mem_wreg==ex_rs.
REQ-025 Otherwise forwardA=01 when wb_RegWrite=1, wb_wreg!=0, and wb_wreg==ex_rs; otherwise 00.
REQ-026 forwardB shall follow the same rule using ex_rt; the EX/MEM match always has priority.
REQ-027 stall_cnt shall increment by 1 per cycle in which REQ-020 applies.
REQ-028 stall_cnt shall saturate at 16'hFFFF.
REQ-029 Register $0 shall never cause a hazard or a forward.
REQ-030 Latency: each ID control reaches its EX output in 1 cycle, MEM output in 2 cycles, and WB output in 3 cycles.

Reset
REQ-031 rst=1 at an edge shall clear all pipeline registers, wreg fields, and stall_cnt to 0.
REQ-032 While rst=1: PCWrite=1, IFIDWrite=1, PCSrc=0, forwardA/B=00.
REQ-033 Reset asserted mid-stall or mid-flush shall abort that operation; the first cycle after release shall act as an empty pipeline.

Verification
REQ-034 LW with rt=8 enters ID, then an R-type with rs=8 enters ID -> one cycle of PCWrite=0/IFIDWrite=0; ex_* = 0 the next cycle; stall_cnt 0->1.
REQ-035 R-type writing rd=9, followed by an R-type reading rs=9 -> forwardA=10 when the second instruction is in EX; with one NOP between them -> forwardA=01.
REQ-036 BEQ with ex_zero=1 -> PCSrc=if_flush=1 when the BEQ is in MEM; the next-cycle ex_RegWrite path and mem_MemWrite are 0.
REQ-037 Load-use hazard coincident with PCSrc=1 -> PCWrite=1; stall_cnt unchanged; bubbles loaded.
REQ-038 Destination $0 with RegWrite=1 followed by a read of $0 -> forwardA/B=00; no stall.
REQ-039 rst pulsed during a stall -> all outputs at reset values next cycle; stall_cnt=0.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-side pipeline for a 5-stage MIPS-style core.
// Carries the decoded control bundle ID->EX->MEM->WB, detects load-use
// hazards (stall + bubble), flushes on a taken branch resolved in MEM,
// selects ALU operand forwarding, and counts load-use stall cycles.
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegDst,
  input  logic        ALUSrc,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic [1:0]  ALUOp,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        ex_zero,
  output logic        ex_RegDst,
  output logic        ex_ALUSrc,
  output logic [1:0]  ex_ALUOp,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [4:0]  ex_wreg,
  output logic [4:0]  mem_wreg,
  output logic [4:0]  wb_wreg,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        PCSrc,
  output logic        if_flush,
  output logic [15:0] stall_cnt
);

  // ID/EX register
  logic       r_ex_RegDst, r_ex_ALUSrc, r_ex_MemtoReg, r_ex_RegWrite;
  logic       r_ex_MemRead, r_ex_MemWrite, r_ex_Branch;
  logic [1:0] r_ex_ALUOp;
  logic [4:0] r_ex_rs, r_ex_rt, r_ex_wreg;
  // EX/MEM register
  logic       r_mem_MemRead, r_mem_MemWrite, r_mem_Branch;
  logic       r_mem_RegWrite, r_mem_MemtoReg, r_mem_zero;
  logic [4:0] r_mem_wreg;
  // MEM/WB register
  logic       r_wb_RegWrite, r_wb_MemtoReg;
  logic [4:0] r_wb_wreg;
  logic [15:0] r_stall_cnt;

  logic w_hazard;
  logic w_pcsrc;
  logic w_stall;

  // A load in EX whose target is read by the ID instruction; $0 never matches.
  assign w_hazard = r_ex_MemRead && (r_ex_rt != 5'd0) &&
                    ((r_ex_rt == id_rs) || (r_ex_rt == id_rt));
  // Branch resolved in MEM; forced low while reset is held.
  assign w_pcsrc  = r_mem_Branch && r_mem_zero && !rst;
  // A taken branch flushes the dependent instruction anyway, so no stall then.
  assign w_stall  = w_hazard && !w_pcsrc && !rst;

  // ID/EX: capture the ID bundle, or a bubble on stall or flush
  always_ff @(posedge clk) begin
    if (rst || w_stall || w_pcsrc) begin
      r_ex_RegDst   <= 1'b0;
      r_ex_ALUSrc   <= 1'b0;
      r_ex_MemtoReg <= 1'b0;
      r_ex_RegWrite <= 1'b0;
      r_ex_MemRead  <= 1'b0;
      r_ex_MemWrite <= 1'b0;
      r_ex_Branch   <= 1'b0;
      r_ex_ALUOp    <= 2'b00;
      r_ex_rs       <= 5'd0;
      r_ex_rt       <= 5'd0;
      r_ex_wreg     <= 5'd0;
    end else begin
      r_ex_RegDst   <= RegDst;
      r_ex_ALUSrc   <= ALUSrc;
      r_ex_MemtoReg <= MemtoReg;
      r_ex_RegWrite <= RegWrite;
      r_ex_MemRead  <= MemRead;
      r_ex_MemWrite <= MemWrite;
      r_ex_Branch   <= Branch;
      r_ex_ALUOp    <= ALUOp;
      r_ex_rs       <= id_rs;
      r_ex_rt       <= id_rt;
      r_ex_wreg     <= RegDst ? id_rd : id_rt;
    end
  end

  // EX/MEM: advance from ID/EX, or a bubble when the branch in MEM is taken
  always_ff @(posedge clk) begin
    if (rst || w_pcsrc) begin
      r_mem_MemRead  <= 1'b0;
      r_mem_MemWrite <= 1'b0;
      r_mem_Branch   <= 1'b0;
      r_mem_RegWrite <= 1'b0;
      r_mem_MemtoReg <= 1'b0;
      r_mem_zero     <= 1'b0;
      r_mem_wreg     <= 5'd0;
    end else begin
      r_mem_MemRead  <= r_ex_MemRead;
      r_mem_MemWrite <= r_ex_MemWrite;
      r_mem_Branch   <= r_ex_Branch;
      r_mem_RegWrite <= r_ex_RegWrite;
      r_mem_MemtoReg <= r_ex_MemtoReg;
      r_mem_zero     <= ex_zero;
      r_mem_wreg     <= r_ex_wreg;
    end
  end

  // MEM/WB: always advances (the branch itself completes)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_RegWrite <= 1'b0;
      r_wb_MemtoReg <= 1'b0;
      r_wb_wreg     <= 5'd0;
    end else begin
      r_wb_RegWrite <= r_mem_RegWrite;
      r_wb_MemtoReg <= r_mem_MemtoReg;
      r_wb_wreg     <= r_mem_wreg;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Operand forwarding: EX/MEM result beats MEM/WB result; $0 never forwards
  always_comb begin
    forwardA = 2'b00;
    forwardB = 2'b00;
    if (!rst) begin
      if (r_mem_RegWrite && (r_mem_wreg != 5'd0) && (r_mem_wreg == r_ex_rs))
        forwardA = 2'b10;
      else if (r_wb_RegWrite && (r_wb_wreg != 5'd0) && (r_wb_wreg == r_ex_rs))
        forwardA = 2'b01;
      if (r_mem_RegWrite && (r_mem_wreg != 5'd0) && (r_mem_wreg == r_ex_rt))
        forwardB = 2'b10;
      else if (r_wb_RegWrite && (r_wb_wreg != 5'd0) && (r_wb_wreg == r_ex_rt))
        forwardB = 2'b01;
    end
  end

  assign PCWrite      = !w_stall;
  assign IFIDWrite    = !w_stall;
  assign PCSrc        = w_pcsrc;
  assign if_flush     = w_pcsrc;
  assign stall_cnt    = r_stall_cnt;
  assign ex_RegDst    = r_ex_RegDst;
  assign ex_ALUSrc    = r_ex_ALUSrc;
  assign ex_ALUOp     = r_ex_ALUOp;
  assign ex_wreg      = r_ex_wreg;
  assign mem_MemRead  = r_mem_MemRead;
  assign mem_MemWrite = r_mem_MemWrite;
  assign mem_wreg     = r_mem_wreg;
  assign wb_RegWrite  = r_wb_RegWrite;
  assign wb_MemtoReg  = r_wb_MemtoReg;
  assign wb_wreg      = r_wb_wreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: table-driven check of ctrl_pipe. Each row gives the ID inputs
// for one cycle and the outputs expected during that cycle (registered
// outputs reflect earlier rows). Expected records go through a scoreboard
// queue; a short hand-written sequence covers reset during a flush.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_zero;
  logic        ex_RegDst, ex_ALUSrc, mem_MemRead, mem_MemWrite;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [1:0]  ex_ALUOp, forwardA, forwardB;
  logic [4:0]  ex_wreg, mem_wreg, wb_wreg;
  logic        PCWrite, IFIDWrite, PCSrc, if_flush;
  logic [15:0] stall_cnt;

  ctrl_pipe dut (
    .clk(clk), .rst(rst),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
    .forwardA(forwardA), .forwardB(forwardB),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .PCSrc(PCSrc), .if_flush(if_flush),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction codes: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}
  localparam logic [8:0] C_NOP = 9'b0000000_00;
  localparam logic [8:0] C_R   = 9'b1001000_10;
  localparam logic [8:0] C_LW  = 9'b0111100_00;
  localparam logic [8:0] C_SW  = 9'b0100010_00;
  localparam logic [8:0] C_BEQ = 9'b0000001_01;

  // ectl = {ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg}
  typedef struct packed {
    logic        rst;
    logic [8:0]  code;
    logic [4:0]  rs, rt, rd;
    logic        zero;
    logic [7:0]  ectl;
    logic [4:0]  exw, memw, wbw;
    logic [1:0]  fa, fb;
    logic        pcw, pcs;
    logic [15:0] sc;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl [NV];
  vec_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic [8:0] c, int rs, int rt, int rd, logic z,
                              logic [7:0] ectl, int exw, int memw, int wbw,
                              logic [1:0] fa, logic [1:0] fb, logic pcw, logic pcs, int sc);
    vec_t v;
    v.rst = r; v.code = c; v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.zero = z;
    v.ectl = ectl; v.exw = 5'(exw); v.memw = 5'(memw); v.wbw = 5'(wbw);
    v.fa = fa; v.fb = fb; v.pcw = pcw; v.pcs = pcs; v.sc = 16'(sc);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [8:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic z);
    rst = r;
    {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp} = c;
    id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
  endtask

  initial begin
    vec_t e;
    //                rst code   rs rt rd z  ectl          exw memw wbw fa     fb     pcw pcs sc
    // load-use stall, then WB forward of the load
    tbl[0]  = mk(0, C_LW,  1, 8, 0, 0, 8'b0000_00_00,  0,  0,  0, 2'b00, 2'b00, 1, 0, 0);
    tbl[1]  = mk(0, C_R,   8, 2, 3, 0, 8'b0100_00_00,  8,  0,  0, 2'b00, 2'b00, 0, 0, 0);
    tbl[2]  = mk(0, C_R,   8, 2, 3, 0, 8'b0000_10_00,  0,  8,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[3]  = mk(0, C_NOP, 0, 0, 0, 0, 8'b1010_00_11,  3,  0,  8, 2'b01, 2'b00, 1, 0, 1);
    // back-to-back dependency -> EX/MEM forward on both operands
    tbl[4]  = mk(0, C_R,   4, 5, 9, 0, 8'b0000_00_00,  0,  3,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[5]  = mk(0, C_R,   9, 9,10, 0, 8'b1010_00_10,  9,  0,  3, 2'b00, 2'b00, 1, 0, 1);
    tbl[6]  = mk(0, C_NOP, 0, 0, 0, 0, 8'b1010_00_00, 10,  9,  0, 2'b10, 2'b10, 1, 0, 1);
    // one NOP between writer and reader -> MEM/WB forward
    tbl[7]  = mk(0, C_R,   1, 2,11, 0, 8'b0000_00_10,  0, 10,  9, 2'b00, 2'b00, 1, 0, 1);
    tbl[8]  = mk(0, C_NOP, 0, 0, 0, 0, 8'b1010_00_10, 11,  0, 10, 2'b00, 2'b00, 1, 0, 1);
    tbl[9]  = mk(0, C_R,  11, 0,12, 0, 8'b0000_00_00,  0, 11,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[10] = mk(0, C_NOP, 0, 0, 0, 0, 8'b1010_00_10, 12,  0, 11, 2'b01, 2'b00, 1, 0, 1);
    // writes to $0 never forward; load to $0 never stalls
    tbl[11] = mk(0, C_R,   1, 2, 0, 0, 8'b0000_00_00,  0, 12,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[12] = mk(0, C_R,   0, 0, 5, 0, 8'b1010_00_10,  0,  0, 12, 2'b00, 2'b00, 1, 0, 1);
    tbl[13] = mk(0, C_NOP, 0, 0, 0, 0, 8'b1010_00_00,  5,  0,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[14] = mk(0, C_LW,  0, 0, 0, 0, 8'b0000_00_10,  0,  5,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[15] = mk(0, C_R,   0, 0, 6, 0, 8'b0100_00_10,  0,  0,  5, 2'b00, 2'b00, 1, 0, 1);
    tbl[16] = mk(0, C_NOP, 0, 0, 0, 0, 8'b1010_10_00,  6,  0,  0, 2'b00, 2'b00, 1, 0, 1);
    // taken BEQ flushes the following SW and R
    tbl[17] = mk(0, C_BEQ, 1, 2, 0, 0, 8'b0000_00_11,  0,  6,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[18] = mk(0, C_SW,  3, 4, 0, 1, 8'b0001_00_10,  2,  0,  6, 2'b00, 2'b00, 1, 0, 1);
    tbl[19] = mk(0, C_R,   5, 6, 7, 0, 8'b0100_00_00,  4,  2,  0, 2'b00, 2'b00, 1, 1, 1);
    tbl[20] = mk(0, C_NOP, 0, 0, 0, 0, 8'b0000_00_00,  0,  0,  2, 2'b00, 2'b00, 1, 0, 1);
    // load-use coincident with taken branch: flush wins, no stall count
    tbl[21] = mk(0, C_BEQ, 1, 2, 0, 0, 8'b0000_00_00,  0,  0,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[22] = mk(0, C_LW,  3, 8, 0, 1, 8'b0001_00_00,  2,  0,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[23] = mk(0, C_R,   8, 8, 9, 0, 8'b0100_00_00,  8,  2,  0, 2'b00, 2'b00, 1, 1, 1);
    tbl[24] = mk(0, C_NOP, 0, 0, 0, 0, 8'b0000_00_00,  0,  0,  2, 2'b00, 2'b00, 1, 0, 1);
    // EX/MEM and MEM/WB both match: EX/MEM has priority
    tbl[25] = mk(0, C_R,   1, 2, 7, 0, 8'b0000_00_00,  0,  0,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[26] = mk(0, C_R,   3, 4, 7, 0, 8'b1010_00_00,  7,  0,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[27] = mk(0, C_R,   7, 7, 1, 0, 8'b1010_00_00,  7,  7,  0, 2'b00, 2'b00, 1, 0, 1);
    tbl[28] = mk(0, C_NOP, 0, 0, 0, 0, 8'b1010_00_10,  1,  7,  7, 2'b10, 2'b10, 1, 0, 1);
    // rt-side load-use stall, then reset while a stall condition is present
    tbl[29] = mk(0, C_LW,  0, 4, 0, 0, 8'b0000_00_10,  0,  1,  7, 2'b00, 2'b00, 1, 0, 1);
    tbl[30] = mk(0, C_R,   0, 4, 5, 0, 8'b0100_00_10,  4,  0,  1, 2'b00, 2'b00, 0, 0, 1);
    tbl[31] = mk(0, C_LW,  0, 6, 0, 0, 8'b0000_10_00,  0,  4,  0, 2'b00, 2'b00, 1, 0, 2);
    tbl[32] = mk(1, C_R,   6, 0, 1, 0, 8'b0100_00_11,  6,  0,  4, 2'b00, 2'b00, 1, 0, 2);
    tbl[33] = mk(0, C_R,   6, 0, 1, 0, 8'b0000_00_00,  0,  0,  0, 2'b00, 2'b00, 1, 0, 0);
    tbl[34] = mk(0, C_NOP, 0, 0, 0, 0, 8'b1010_00_00,  1,  0,  0, 2'b00, 2'b00, 1, 0, 0);

    drive(1'b1, C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].code, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].zero);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("[TB] vec %0d: pcw=%0b pcs=%0b fa=%0b fb=%0b ex/mem/wb wreg=%0d/%0d/%0d sc=%0d",
               i, PCWrite, PCSrc, forwardA, forwardB, ex_wreg, mem_wreg, wb_wreg, stall_cnt);
      chk("ectl",      i, 32'({ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
                               wb_RegWrite, wb_MemtoReg}), 32'(e.ectl));
      chk("ex_wreg",   i, 32'(ex_wreg),   32'(e.exw));
      chk("mem_wreg",  i, 32'(mem_wreg),  32'(e.memw));
      chk("wb_wreg",   i, 32'(wb_wreg),   32'(e.wbw));
      chk("forwardA",  i, 32'(forwardA),  32'(e.fa));
      chk("forwardB",  i, 32'(forwardB),  32'(e.fb));
      chk("PCWrite",   i, 32'(PCWrite),   32'(e.pcw));
      chk("IFIDWrite", i, 32'(IFIDWrite), 32'(e.pcw));
      chk("PCSrc",     i, 32'(PCSrc),     32'(e.pcs));
      chk("if_flush",  i, 32'(if_flush),  32'(e.pcs));
      chk("stall_cnt", i, 32'(stall_cnt), 32'(e.sc));
      @(posedge clk);
      #1;
    end

    // Hand sequence: reset asserted in the cycle a taken branch reaches MEM
    drive(1'b0, C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, C_NOP, 5'd0, 5'd0, 5'd0, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    $display("[TB] rst during flush: PCSrc=%0b if_flush=%0b PCWrite=%0b", PCSrc, if_flush, PCWrite);
    chk("rst_pcsrc",   100, 32'(PCSrc),    32'd0);
    chk("rst_if_flush",100, 32'(if_flush), 32'd0);
    chk("rst_pcwrite", 100, 32'(PCWrite),  32'd1);
    @(posedge clk); #1;
    drive(1'b0, C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    $display("[TB] after rst release: PCSrc=%0b wb_wreg=%0d wb_RegWrite=%0b sc=%0d",
             PCSrc, wb_wreg, wb_RegWrite, stall_cnt);
    chk("post_rst_pcsrc",  101, 32'(PCSrc),     32'd0);
    chk("post_rst_wbwreg", 101, 32'(wb_wreg),   32'd0);
    chk("post_rst_ex",     101, 32'({ex_RegDst, ex_ALUSrc, ex_ALUOp}), 32'd0);
    chk("post_rst_sc",     101, 32'(stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
